// File: rtl/sextans_arith_pkg.sv
// Shared arithmetic helpers for the Sextans MAC pipeline: operand extension,
// signed saturation and the legal pipeline depth range.
package sextans_arith_pkg;

    localparam int MAX_W     = 64;
    localparam int MIN_STAGE = 2;
    localparam int MAX_STAGE = 8;

    function automatic int full_w(input int a_w, input int b_w);
        return a_w + b_w + 1;
    endfunction

    function automatic bit stage_ok(input int n);
        return (n >= MIN_STAGE) && (n <= MAX_STAGE);
    endfunction

    // Low `width` bits of x are the value; upper bits become sign or zero fill.
    function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] x,
                                                input logic sgn,
                                                input int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) r[i] = x[i];
            else           r[i] = sgn & x[width-1];
        end
        return r;
    endfunction

    // Treat x as a signed from_w-bit value and clamp into the signed to_w range.
    function automatic logic [MAX_W-1:0] sat_narrow(input logic [MAX_W-1:0] x,
                                                    input int from_w,
                                                    input int to_w);
        logic signed [MAX_W-1:0] v;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        v          = signed'(extend(x, 1'b1, from_w));
        hi         = '0;
        hi[to_w-1] = 1'b1;
        hi         = hi - MAX_W'(1);
        lo         = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/sextans_mac_pipe_if.sv
// Valid/ready bus of the MAC pipeline: an input beat channel and a result channel.
// A beat moves on a channel in every cycle where its valid and ready are both high.
interface sextans_mac_pipe_if #(
    parameter int A_WIDTH = 14,
    parameter int B_WIDTH = 28,
    parameter int P_WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [A_WIDTH-1:0] in_a;
    logic [B_WIDTH-1:0] in_b;
    logic               in_first;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [P_WIDTH-1:0] out_p;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/sextans_mul_core.sv
// Registered exact multiplier: input register stage, then NUM_STAGE-2 product
// registers, all advancing together on i_en so the chain maps onto DSP cascades.
module sextans_mul_core
    import sextans_arith_pkg::*;
#(
    parameter  int A_WIDTH   = 14,
    parameter  int B_WIDTH   = 28,
    parameter  int A_SIGNED  = 0,
    parameter  int B_SIGNED  = 1,
    parameter  int NUM_STAGE = 4,
    localparam int FULL_W    = A_WIDTH + B_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [A_WIDTH-1:0]       i_a,
    input  logic [B_WIDTH-1:0]       i_b,
    output logic signed [FULL_W-1:0] o_prod
);
    logic signed [FULL_W-1:0] r_a;
    logic signed [FULL_W-1:0] r_b;
    logic signed [FULL_W-1:0] w_prod;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_a <= FULL_W'(extend(MAX_W'(i_a), (A_SIGNED != 0), A_WIDTH));
            r_b <= FULL_W'(extend(MAX_W'(i_b), (B_SIGNED != 0), B_WIDTH));
        end
    end

    // FULL_W bits always hold the exact product, so truncating the multiply loses nothing.
    assign w_prod = r_a * r_b;

    if (NUM_STAGE == 2) begin : g_no_pipe
        assign o_prod = w_prod;
    end else begin : g_pipe
        logic signed [FULL_W-1:0] r_pipe [NUM_STAGE-2];

        always_ff @(posedge clk) begin
            if (i_en) begin
                r_pipe[0] <= w_prod;
                for (int i = 1; i < NUM_STAGE - 2; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign o_prod = r_pipe[NUM_STAGE-3];
    end
endmodule

// File: rtl/sextans_mac_pipe.sv
// Pipelined multiply / multiply-accumulate with a global stall on result backpressure.
// Owns the valid/flag shift register, the final narrow/accumulate stage and the handshake.
module sextans_mac_pipe
    import sextans_arith_pkg::*;
#(
    parameter int A_WIDTH   = 14,
    parameter int B_WIDTH   = 28,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 1,
    parameter int P_WIDTH   = 32,
    parameter int NUM_STAGE = 4,
    parameter int ACC_MODE  = 0,
    parameter int SATURATE  = 0
) (
    input logic               clk,
    input logic               reset,
    sextans_mac_pipe_if.slave bus
);
    localparam int FULL_W = full_w(A_WIDTH, B_WIDTH);
    localparam int LAST   = NUM_STAGE - 2;

    if (!stage_ok(NUM_STAGE)) begin : g_bad_stage
        $error("sextans_mac_pipe: NUM_STAGE must lie in 2..8");
    end
    if ((P_WIDTH > FULL_W) || (FULL_W > MAX_W)) begin : g_bad_width
        $error("sextans_mac_pipe: need P_WIDTH <= A_WIDTH+B_WIDTH+1 <= 64");
    end

    logic                      w_stall;
    logic                      w_en;
    logic                      w_accept;
    logic                      w_emit;
    logic [LAST:0]             r_vld;
    logic [LAST:0]             r_first;
    logic [LAST:0]             r_last;
    logic signed [FULL_W-1:0]  w_prod;
    logic signed [P_WIDTH-1:0] w_narrow;
    logic signed [P_WIDTH:0]   w_sum;
    logic signed [P_WIDTH-1:0] w_acc;
    logic signed [P_WIDTH-1:0] w_next;
    logic signed [P_WIDTH-1:0] r_acc;
    logic signed [P_WIDTH-1:0] r_out_p;
    logic                      r_out_valid;

    assign w_stall      = r_out_valid & ~bus.out_ready;
    assign w_en         = ~w_stall;
    assign w_accept     = bus.in_valid & w_en;
    assign bus.in_ready = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_out_p;

    sextans_mul_core #(
        .A_WIDTH  (A_WIDTH),
        .B_WIDTH  (B_WIDTH),
        .A_SIGNED (A_SIGNED),
        .B_SIGNED (B_SIGNED),
        .NUM_STAGE(NUM_STAGE)
    ) u_mul (
        .clk   (clk),
        .i_en  (w_en),
        .i_a   (bus.in_a),
        .i_b   (bus.in_b),
        .o_prod(w_prod)
    );

    // Wrap mode keeps the low bits; saturate mode clamps the product and again after each add.
    assign w_sum = {r_acc[P_WIDTH-1], r_acc} + {w_narrow[P_WIDTH-1], w_narrow};

    always_comb begin
        w_narrow = P_WIDTH'(w_prod);
        w_acc    = w_sum[P_WIDTH-1:0];
        if (SATURATE != 0) begin
            w_narrow = P_WIDTH'(sat_narrow(MAX_W'(w_prod), FULL_W, P_WIDTH));
            w_acc    = P_WIDTH'(sat_narrow(MAX_W'(w_sum), P_WIDTH + 1, P_WIDTH));
        end
        w_next = w_acc;
        if ((ACC_MODE == 0) || r_first[LAST]) w_next = w_narrow;
    end

    assign w_emit = r_vld[LAST] & ((ACC_MODE == 0) | r_last[LAST]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld       <= '0;
            r_first     <= '0;
            r_last      <= '0;
            r_acc       <= '0;
            r_out_p     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_vld[0]   <= w_accept;
            r_first[0] <= bus.in_first;
            r_last[0]  <= bus.in_last;
            for (int i = 1; i <= LAST; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_first[i] <= r_first[i-1];
                r_last[i]  <= r_last[i-1];
            end
            r_out_valid <= w_emit;
            if (r_vld[LAST]) r_acc <= w_next;
            if (w_emit) r_out_p <= w_next;
        end
    end
endmodule

// File: tb/tb_sextans_mac_pipe.sv
// Self-checking bench for sextans_mac_pipe: four configurations (default, saturating,
// accumulate, accumulate+saturate at 16 bits) driven from one sequenced initial block.
module tb_sextans_mac_pipe;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] exp_q0[$];
    int          due_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];
    logic [15:0] exp_q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sextans_mac_pipe_if #(.A_WIDTH(14), .B_WIDTH(28), .P_WIDTH(32)) if0 ();
    sextans_mac_pipe_if #(.A_WIDTH(14), .B_WIDTH(28), .P_WIDTH(32)) if1 ();
    sextans_mac_pipe_if #(.A_WIDTH(14), .B_WIDTH(28), .P_WIDTH(32)) if2 ();
    sextans_mac_pipe_if #(.A_WIDTH(14), .B_WIDTH(28), .P_WIDTH(16)) if3 ();

    sextans_mac_pipe u_d0 (.clk(clk), .reset(reset), .bus(if0));
    sextans_mac_pipe #(.SATURATE(1)) u_d1 (.clk(clk), .reset(reset), .bus(if1));
    sextans_mac_pipe #(.ACC_MODE(1)) u_d2 (.clk(clk), .reset(reset), .bus(if2));
    sextans_mac_pipe #(.P_WIDTH(16), .ACC_MODE(1), .SATURATE(1)) u_d3 (.clk(clk), .reset(reset), .bus(if3));

    function automatic longint prod_ab(input logic [13:0] a, input logic [27:0] b);
        longint la;
        longint lb;
        la = longint'(a);
        lb = longint'(signed'(b));
        return la * lb;
    endfunction

    function automatic longint wrapw(input longint v, input int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    function automatic longint clamp(input longint v, input int w);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    task automatic idle_all();
        if0.in_valid = 0; if0.in_a = '0; if0.in_b = '0; if0.in_first = 0; if0.in_last = 0; if0.out_ready = 1;
        if1.in_valid = 0; if1.in_a = '0; if1.in_b = '0; if1.in_first = 0; if1.in_last = 0; if1.out_ready = 1;
        if2.in_valid = 0; if2.in_a = '0; if2.in_b = '0; if2.in_first = 0; if2.in_last = 0; if2.out_ready = 1;
        if3.in_valid = 0; if3.in_a = '0; if3.in_b = '0; if3.in_first = 0; if3.in_last = 0; if3.out_ready = 1;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        n_vec++;
        if (if0.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", if0.out_valid); end
        n_vec++;
        if (if0.out_p !== 32'h0) begin n_err++; $display("FAIL reset_out_p: got %h expected 00000000", if0.out_p); end
        n_vec++;
        if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", if0.in_ready); end
        n_vec++;
        if (if2.out_valid !== 1'b0 || if3.out_p !== 16'h0) begin
            n_err++; $display("FAIL reset_acc_units: got valid %b p %h expected 0 0000", if2.out_valid, if3.out_p);
        end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        if0.in_valid = 1; if0.in_a = 14'd3; if0.in_b = 28'hFFFFFFB;
        @(negedge clk);
        n_vec++;
        if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL latency_accept: got in_ready %b expected 1", if0.in_ready); end
        @(posedge clk); #1;
        if0.in_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_vec++;
            if (if0.out_valid !== (k == 4)) begin
                n_err++; $display("FAIL latency_valid: cycle +%0d got %b expected %b", k, if0.out_valid, (k == 4));
            end
            if (k == 4) begin
                n_vec++;
                if (if0.out_p !== 32'hFFFFFFF1) begin n_err++; $display("FAIL latency_value: got %h expected fffffff1", if0.out_p); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] a;
        logic [27:0] b;
        logic [31:0] e;
        int          due;
        int          got;
        got = 0;
        a = '0;
        b = '0;
        for (int c = 0; c < 26; c++) begin
            @(posedge clk); #1;
            if (c < 16) begin
                a = 14'($urandom_range(0, 16383));
                b = 28'($urandom());
                if0.in_valid = 1; if0.in_a = a; if0.in_b = b;
            end else begin
                if0.in_valid = 0;
            end
            @(negedge clk);
            if (if0.out_valid) begin
                n_vec++;
                got++;
                if (exp_q0.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra: got %h with nothing expected", if0.out_p);
                end else begin
                    e   = exp_q0.pop_front();
                    due = due_q0.pop_front();
                    if (if0.out_p !== e || cyc != due) begin
                        n_err++; $display("FAIL b2b_data: got %h at cycle %0d expected %h at cycle %0d", if0.out_p, cyc, e, due);
                    end
                end
            end
            if (if0.in_valid && if0.in_ready) begin
                exp_q0.push_back(32'(prod_ab(a, b)));
                due_q0.push_back(cyc + 4);
            end
        end
        n_vec++;
        if (got != 16 || exp_q0.size() != 0) begin
            n_err++; $display("FAIL b2b_count: got %0d outputs expected 16 (pending %0d)", got, exp_q0.size());
        end
        exp_q0.delete();
        due_q0.delete();
    endtask

    task automatic test_wrap();
        logic [13:0] av [3] = '{14'd16383, 14'd16383, 14'd3};
        logic [27:0] bv [3] = '{28'h8000000, 28'h7FFFFFF, 28'hFFFFFFB};
        logic [31:0] e;
        longint      p;
        int          sent;
        int          got0;
        int          got1;
        sent = 0; got0 = 0; got1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if0.in_valid = (sent < 3);
            if1.in_valid = (sent < 3);
            if (sent < 3) begin
                if0.in_a = av[sent]; if0.in_b = bv[sent];
                if1.in_a = av[sent]; if1.in_b = bv[sent];
            end
            @(negedge clk);
            if (if0.out_valid) begin
                n_vec++; got0++;
                e = (exp_q0.size() != 0) ? exp_q0.pop_front() : 32'hx;
                if (if0.out_p !== e) begin n_err++; $display("FAIL wrap_value: got %h expected %h", if0.out_p, e); end
            end
            if (if1.out_valid) begin
                n_vec++; got1++;
                e = (exp_q1.size() != 0) ? exp_q1.pop_front() : 32'hx;
                if (if1.out_p !== e) begin n_err++; $display("FAIL sat_value: got %h expected %h", if1.out_p, e); end
            end
            if (if0.in_valid && if0.in_ready && if1.in_ready) begin
                p = prod_ab(av[sent], bv[sent]);
                exp_q0.push_back(32'(p));
                exp_q1.push_back(32'(clamp(p, 32)));
                sent++;
            end
        end
        n_vec++;
        if (got0 != 3 || got1 != 3) begin n_err++; $display("FAIL wrap_count: got %0d/%0d outputs expected 3/3", got0, got1); end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic test_stall();
        logic [13:0] av [8];
        logic [27:0] bv [8];
        logic [31:0] e;
        logic [31:0] prev_p;
        logic        stall_win;
        int          sent;
        int          got;
        sent = 0; got = 0; prev_p = '0;
        for (int i = 0; i < 8; i++) begin
            av[i] = 14'($urandom_range(0, 16383));
            bv[i] = 28'($urandom());
        end
        for (int c = 0; c < 30 && got < 8; c++) begin
            stall_win = (c >= 6) && (c <= 8);
            @(posedge clk); #1;
            if0.out_ready = !stall_win;
            if0.in_valid  = (sent < 8);
            if (sent < 8) begin if0.in_a = av[sent]; if0.in_b = bv[sent]; end
            @(negedge clk);
            if (c < 12) begin
                n_vec++;
                if (if0.in_ready !== !stall_win) begin
                    n_err++; $display("FAIL stall_in_ready: cycle %0d got %b expected %b", c, if0.in_ready, !stall_win);
                end
            end
            if (c >= 7 && c <= 9) begin
                n_vec++;
                if (if0.out_p !== prev_p || if0.out_valid !== 1'b1) begin
                    n_err++; $display("FAIL stall_hold: cycle %0d got %h valid %b expected %h valid 1", c, if0.out_p, if0.out_valid, prev_p);
                end
            end
            prev_p = if0.out_p;
            if (if0.out_valid && if0.out_ready) begin
                n_vec++; got++;
                e = (exp_q0.size() != 0) ? exp_q0.pop_front() : 32'hx;
                if (if0.out_p !== e) begin n_err++; $display("FAIL stall_order: got %h expected %h", if0.out_p, e); end
            end
            if (if0.in_valid && if0.in_ready) begin
                exp_q0.push_back(32'(prod_ab(av[sent], bv[sent])));
                sent++;
            end
        end
        @(posedge clk); #1;
        if0.out_ready = 1; if0.in_valid = 0;
        n_vec++;
        if (got != 8 || exp_q0.size() != 0) begin
            n_err++; $display("FAIL stall_count: got %0d outputs expected 8 (pending %0d)", got, exp_q0.size());
        end
        exp_q0.delete();
    endtask

    task automatic test_acc();
        logic [13:0] av [5] = '{14'd2, 14'd4, 14'd1, 14'd5, 14'd1};
        logic [27:0] bv [5] = '{28'd3, 28'hFFFFFFF, 28'd10, 28'd5, 28'd1};
        logic        fv [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        lv [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] e;
        longint      acc;
        int          sent;
        int          got;
        acc = 0; sent = 0; got = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if2.in_valid = (sent < 5);
            if (sent < 5) begin
                if2.in_a = av[sent]; if2.in_b = bv[sent]; if2.in_first = fv[sent]; if2.in_last = lv[sent];
            end
            @(negedge clk);
            if (if2.out_valid) begin
                n_vec++; got++;
                e = (exp_q2.size() != 0) ? exp_q2.pop_front() : 32'hx;
                if (if2.out_p !== e) begin n_err++; $display("FAIL acc_group: got %h expected %h", if2.out_p, e); end
            end
            if (if2.in_valid && if2.in_ready) begin
                acc = fv[sent] ? wrapw(prod_ab(av[sent], bv[sent]), 32)
                               : wrapw(acc + wrapw(prod_ab(av[sent], bv[sent]), 32), 32);
                if (lv[sent]) exp_q2.push_back(32'(acc));
                sent++;
            end
        end
        n_vec++;
        if (got != 3 || exp_q2.size() != 0) begin n_err++; $display("FAIL acc_count: got %0d outputs expected 3", got); end
        exp_q2.delete();
    endtask

    task automatic test_acc_sat();
        logic [13:0] av [10] = '{14'd255, 14'd255, 14'd255, 14'd255, 14'd255, 14'd255, 14'd255, 14'd1, 14'd1, 14'd16383};
        logic [27:0] bv [10] = '{28'd255, 28'd255, 28'd255, 28'd255, 28'd255, 28'd255, 28'd255,
                                 28'hFFFFFFD, 28'hFFFFFFC, 28'h8000000};
        logic        fv [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        lv [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] e;
        longint      acc;
        int          sent;
        int          got;
        acc = 0; sent = 0; got = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if3.in_valid = (sent < 10);
            if (sent < 10) begin
                if3.in_a = av[sent]; if3.in_b = bv[sent]; if3.in_first = fv[sent]; if3.in_last = lv[sent];
            end
            @(negedge clk);
            if (if3.out_valid) begin
                n_vec++; got++;
                e = (exp_q3.size() != 0) ? exp_q3.pop_front() : 16'hx;
                if (if3.out_p !== e) begin n_err++; $display("FAIL accsat_group: got %h expected %h", if3.out_p, e); end
            end
            if (if3.in_valid && if3.in_ready) begin
                acc = fv[sent] ? clamp(prod_ab(av[sent], bv[sent]), 16)
                               : clamp(acc + clamp(prod_ab(av[sent], bv[sent]), 16), 16);
                if (lv[sent]) exp_q3.push_back(16'(acc));
                sent++;
            end
        end
        n_vec++;
        if (got != 3 || exp_q3.size() != 0) begin n_err++; $display("FAIL accsat_count: got %0d outputs expected 3", got); end
        exp_q3.delete();
    endtask

    task automatic test_reset_mid();
        logic [13:0] av [3] = '{14'd3, 14'd7, 14'd100};
        logic [27:0] bv [3] = '{28'hFFFFFFB, 28'd7, 28'd2};
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if0.in_valid = (c < 3) || (c == 6);
            if (c < 3) begin if0.in_a = av[c]; if0.in_b = bv[c]; end
            if (c == 6) begin if0.in_a = 14'd5; if0.in_b = 28'd9; end
            reset = (c == 3);
            if2.in_valid = (c == 6);
            if2.in_a = 14'd2; if2.in_b = 28'd2; if2.in_first = 0; if2.in_last = 1;
            @(negedge clk);
            n_vec++;
            if (if0.out_valid !== (c == 10)) begin
                n_err++; $display("FAIL rstmid_valid: cycle %0d got %b expected %b", c, if0.out_valid, (c == 10));
            end
            if (c >= 4 && c < 10) begin
                n_vec++;
                if (if0.out_p !== 32'h0) begin n_err++; $display("FAIL rstmid_out_p: cycle %0d got %h expected 00000000", c, if0.out_p); end
            end
            if (c == 4) begin
                n_vec++;
                if (if0.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b expected 1", if0.in_ready); end
            end
            if (c == 10) begin
                n_vec++;
                if (if0.out_p !== 32'd45) begin n_err++; $display("FAIL rstmid_new_beat: got %h expected 0000002d", if0.out_p); end
                n_vec++;
                if (if2.out_valid !== 1'b1 || if2.out_p !== 32'd4) begin
                    n_err++; $display("FAIL rstmid_acc_cleared: got valid %b p %h expected valid 1 p 00000004", if2.out_valid, if2.out_p);
                end
            end
        end
        if0.in_valid = 0;
        if2.in_valid = 0;
    endtask

    initial begin
        idle_all();
        test_reset();
        test_latency();
        test_back_to_back();
        test_wrap();
        test_stall();
        test_acc();
        test_acc_sat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
